// File: rtl/ro_freq_counter.sv
// Gated frequency counter for the eight ring-oscillator returns: synchronise, count rising
// edges over a fixed window, then latch the eight counts for the serial output stage.
module ro_freq_counter #(
  parameter int unsigned GATE_CYCLES   = 1000000,
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic        data_clk,
  input  logic        reset,
  input  logic [7:0]  ro_in,
  input  logic [1:0]  sel,
  output logic [31:0] INV_COUNT0,
  output logic [31:0] NAND_COUNT0,
  output logic [31:0] NOR_COUNT0,
  output logic [31:0] DividerOutput_COUNT0,
  output logic [31:0] INV_COUNT1,
  output logic [31:0] NAND_COUNT1,
  output logic [31:0] NOR_COUNT1,
  output logic [31:0] DividerOutput_COUNT1,
  output logic [1:0]  sel_latched,
  output logic        count_valid
);

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [31:0] GATE_LAST   = 32'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {SETTLE, COUNT, LATCH} state_t;

  state_t            state;
  state_t            next_state;
  logic [7:0]        s1;
  logic [7:0]        s2;
  logic [7:0]        s3;
  logic [7:0]        rise;
  logic [15:0]       settle_cnt;
  logic [31:0]       window_cnt;
  logic [7:0][31:0]  edge_cnt;
  logic [7:0][31:0]  held;
  logic [1:0]        sel_q;
  logic              sel_change;
  logic              latch_done;

  assign rise       = s2 & ~s3;
  assign sel_change = (sel != sel_q);

  // s1 may go metastable; only s2/s3 feed edge detection.
  always_ff @(posedge data_clk) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= ro_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge data_clk) begin
    if (!reset) state <= SETTLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    latch_done = 1'b0;
    case (state)
      SETTLE: if (settle_cnt == SETTLE_LAST) next_state = COUNT;
      COUNT:  if (window_cnt == GATE_LAST) next_state = LATCH;
      LATCH: begin
        next_state = COUNT;
        latch_done = 1'b1;
      end
      default: next_state = SETTLE;
    endcase
    // A bank switch invalidates the window in progress, including one finishing this edge.
    if (sel_change) begin
      next_state = SETTLE;
      latch_done = 1'b0;
    end
  end

  always_ff @(posedge data_clk) begin
    if (!reset) begin
      settle_cnt <= '0;
      window_cnt <= '0;
      edge_cnt   <= '0;
      sel_q      <= sel;
    end else if (sel_change) begin
      settle_cnt <= '0;
      window_cnt <= '0;
      edge_cnt   <= '0;
      sel_q      <= sel;
    end else begin
      case (state)
        SETTLE: settle_cnt <= settle_cnt + 16'd1;
        COUNT: begin
          window_cnt <= window_cnt + 32'd1;
          for (int i = 0; i < 8; i++) begin
            if (rise[i]) edge_cnt[i] <= edge_cnt[i] + 32'd1;
          end
        end
        LATCH: begin
          window_cnt <= '0;
          edge_cnt   <= '0;
        end
        default: settle_cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge data_clk) begin
    if (!reset) begin
      held        <= '0;
      sel_latched <= '0;
      count_valid <= 1'b0;
    end else begin
      count_valid <= latch_done;
      if (latch_done) begin
        held        <= edge_cnt;
        sel_latched <= sel_q;
      end
    end
  end

  assign INV_COUNT0           = held[0];
  assign NAND_COUNT0          = held[1];
  assign NOR_COUNT0           = held[2];
  assign DividerOutput_COUNT0 = held[3];
  assign INV_COUNT1           = held[4];
  assign NAND_COUNT1          = held[5];
  assign NOR_COUNT1           = held[6];
  assign DividerOutput_COUNT1 = held[7];

endmodule

// File: tb/tb_ro_freq_counter.sv
// Scoreboard bench for ro_freq_counter with GATE_CYCLES=100, SETTLE_CYCLES=4; expected
// windows are queued by the stimulus and checked by a monitor on every count_valid pulse.
module tb_ro_freq_counter;

  localparam int unsigned GATE   = 100;
  localparam int unsigned SETTLE = 4;
  localparam int unsigned PERIOD = GATE + 1;

  typedef struct packed {
    logic [31:0]      cyc;
    logic [1:0]       sel;
    logic             chk;
    logic [7:0][31:0] cnt;
  } exp_t;

  logic        data_clk = 1'b0;
  logic        reset;
  logic [7:0]  ro_in = '0;
  logic [1:0]  sel;
  logic [31:0] INV_COUNT0, NAND_COUNT0, NOR_COUNT0, DividerOutput_COUNT0;
  logic [31:0] INV_COUNT1, NAND_COUNT1, NOR_COUNT1, DividerOutput_COUNT1;
  logic [1:0]  sel_latched;
  logic        count_valid;

  logic [7:0][31:0] act;
  exp_t             expQ[$];
  exp_t             monEntry;
  int unsigned      cyc = 0;
  int unsigned      roPeriod[8] = '{default: 0};
  int unsigned      nextV;
  int unsigned      lastV;
  int               checks = 0;
  int               errors = 0;

  ro_freq_counter #(.GATE_CYCLES(GATE), .SETTLE_CYCLES(SETTLE)) dut (
    .data_clk(data_clk), .reset(reset), .ro_in(ro_in), .sel(sel),
    .INV_COUNT0(INV_COUNT0), .NAND_COUNT0(NAND_COUNT0), .NOR_COUNT0(NOR_COUNT0),
    .DividerOutput_COUNT0(DividerOutput_COUNT0),
    .INV_COUNT1(INV_COUNT1), .NAND_COUNT1(NAND_COUNT1), .NOR_COUNT1(NOR_COUNT1),
    .DividerOutput_COUNT1(DividerOutput_COUNT1),
    .sel_latched(sel_latched), .count_valid(count_valid)
  );

  assign act = {DividerOutput_COUNT1, NOR_COUNT1, NAND_COUNT1, INV_COUNT1,
                DividerOutput_COUNT0, NOR_COUNT0, NAND_COUNT0, INV_COUNT0};

  always #5 data_clk = ~data_clk;

  always @(posedge data_clk) cyc <= cyc + 1;

  // Synchronous RO model: 50% duty square wave per channel, period in clocks (0 = off).
  always @(negedge data_clk) begin
    for (int i = 0; i < 8; i++)
      ro_in[i] = (roPeriod[i] != 0) && ((cyc % roPeriod[i]) < (roPeriod[i] / 2));
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  task automatic checkHeld(input string tag, input logic [7:0][31:0] cnt,
                           input logic [1:0] selExp, input logic validExp);
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("%s_count%0d", tag, i), act[i], cnt[i]);
    checkOutput({tag, "_sel_latched"}, 32'(sel_latched), 32'(selExp));
    checkOutput({tag, "_count_valid"}, 32'(count_valid), 32'(validExp));
  endtask

  function automatic logic [7:0][31:0] cntOf(input int a, input logic [31:0] va,
                                             input int b, input logic [31:0] vb);
    logic [7:0][31:0] c;
    c = '0;
    if (a >= 0) c[a] = va;
    if (b >= 0) c[b] = vb;
    return c;
  endfunction

  task automatic waitCycle(input int unsigned t);
    while (cyc < t) @(negedge data_clk);
  endtask

  task automatic expectWindows(input int n, input logic [1:0] s, input logic chk,
                               input logic [7:0][31:0] cnt);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.cyc = nextV;
      e.sel = s;
      e.chk = chk;
      e.cnt = cnt;
      expQ.push_back(e);
      lastV = nextV;
      nextV = nextV + PERIOD;
    end
  endtask

  task automatic drain();
    waitCycle(lastV);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain at cycle %0d: %0d windows still pending, expected 0",
               cyc, expQ.size());
      expQ.delete();
    end
  endtask

  // Monitor: every count_valid pulse must match the oldest queued window.
  always @(negedge data_clk) begin
    if (count_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_valid at cycle %0d: got pulse, expected none", cyc);
      end else begin
        monEntry = expQ.pop_front();
        checkOutput("valid_cycle", cyc, monEntry.cyc);
        checkOutput("valid_sel_latched", 32'(sel_latched), 32'(monEntry.sel));
        if (monEntry.chk)
          for (int i = 0; i < 8; i++)
            checkOutput($sformatf("valid_count%0d", i), act[i], monEntry.cnt[i]);
      end
    end
  end

  task automatic applyStimulus();
    int unsigned v;
    int unsigned r;
    logic [7:0][31:0] zero;
    zero = '0;

    // Power-on reset with sel=1, all ROs quiet.
    reset = 1'b0;
    sel   = 2'd1;
    repeat (3) @(negedge data_clk);
    checkHeld("reset", zero, 2'd0, 1'b0);
    reset = 1'b1;
    nextV = cyc + SETTLE + GATE + 1;
    expectWindows(2, 2'd1, 1'b1, zero);
    drain();

    roPeriod[0] = 4;
    expectWindows(1, 2'd1, 1'b0, zero);
    expectWindows(2, 2'd1, 1'b1, cntOf(0, 25, -1, 0));
    drain();

    roPeriod[0] = 0;
    roPeriod[3] = 10;
    roPeriod[7] = 2;
    expectWindows(1, 2'd1, 1'b0, zero);
    expectWindows(2, 2'd1, 1'b1, cntOf(3, 10, 7, 50));
    drain();

    // Bank switch halfway through a window; old counts must be held until the new result.
    v = lastV;
    waitCycle(v + 50);
    sel = 2'd2;
    roPeriod[3] = 0;
    roPeriod[7] = 0;
    roPeriod[1] = 4;
    nextV = v + 51 + SETTLE + GATE + 1;
    expectWindows(1, 2'd2, 1'b1, cntOf(1, 25, -1, 0));
    waitCycle(v + 101);
    checkHeld("selmid_a", cntOf(3, 10, 7, 50), 2'd1, 1'b0);
    waitCycle(v + 155);
    checkHeld("selmid_b", cntOf(3, 10, 7, 50), 2'd1, 1'b0);
    drain();

    // Bank switch on the edge that ends LATCH.
    v = lastV;
    waitCycle(v + 100);
    sel = 2'd3;
    nextV = v + 101 + SETTLE + GATE + 1;
    expectWindows(1, 2'd3, 1'b1, cntOf(1, 25, -1, 0));
    waitCycle(v + 101);
    checkHeld("sellatch_a", cntOf(1, 25, -1, 0), 2'd2, 1'b0);
    waitCycle(v + 205);
    checkHeld("sellatch_b", cntOf(1, 25, -1, 0), 2'd2, 1'b0);
    drain();

    roPeriod[1] = 0;
    roPeriod[0] = 4;
    expectWindows(1, 2'd3, 1'b0, zero);
    expectWindows(1, 2'd3, 1'b1, cntOf(0, 25, -1, 0));
    drain();

    // Reset in the middle of a counting window.
    v = lastV;
    waitCycle(v + 30);
    reset = 1'b0;
    waitCycle(v + 31);
    checkHeld("midreset", zero, 2'd0, 1'b0);
    waitCycle(v + 32);
    reset = 1'b1;
    r = cyc;
    nextV = r + SETTLE + GATE + 1;
    expectWindows(1, 2'd3, 1'b1, cntOf(0, 25, -1, 0));
    drain();
  endtask

  initial begin
    applyStimulus();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #60000;
    $display("[TB] FAIL watchdog at cycle %0d: simulation did not complete, expected finish", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
